// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   state_t : arbiter FSM states (idle, waiting for read data)
//   owner_t : which requester owns the outstanding transaction
//   LDST_*  : LSU access size codes
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } owner_t;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // Latency counter holds MEM_LAT-1 (0..3); starvation counter holds 0..STARVE_LIM (max 7).
    localparam int unsigned LAT_W    = 2;
    localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/lsu_data_align.sv
// Purely combinational LSU data alignment.
//   Request side : req_size_i/req_off_i/req_wdata_i -> be_o, wdata_o (lane-placed
//                  store data), misaligned_o (bad alignment or illegal size code).
//   Response side: rsp_size_i/rsp_off_i (latched at grant) and rsp_rdata_i (memory
//                  word) -> rdata_o (lane-selected, sign/zero-extended load data).
module lsu_data_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [2:0]  rsp_size_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (req_size_i)
            LDST_B, LDST_BU: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be_o         = 4'b0011 << req_off_i;
                wdata_o      = {2{req_wdata_i[15:0]}};
                misaligned_o = req_off_i[0];
            end
            LDST_W: begin
                be_o         = 4'b1111;
                wdata_o      = req_wdata_i;
                misaligned_o = (req_off_i != 2'b00);
            end
            default: misaligned_o = 1'b1;
        endcase
    end

    // Halfword lane is chosen by offset bit 1 only; bit 0 is zero for legal halfwords.
    assign byte_sel = rsp_rdata_i[{rsp_off_i, 3'b000} +: 8];
    assign half_sel = rsp_rdata_i[{rsp_off_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = 32'h0;
        case (rsp_size_i)
            LDST_B:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rdata_o = {24'h0, byte_sel};
            LDST_H:  rdata_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rdata_o = {16'h0, half_sel};
            LDST_W:  rdata_o = rsp_rdata_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   if_*                   : fetch request/grant/response (word reads only)
//   lsu_*                  : data request/grant/response with size, store data, error
//   mem_*                  : memory strobe, write, byte enables, word address, data
//   busy_o                 : a transaction is outstanding
// One transaction is outstanding at most. The LSU wins arbitration unless fetch has
// been denied STARVE_LIM times in a row. Read data returns MEM_LAT cycles after grant;
// a new grant may be issued in the response cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_LIM = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    state_t              state_q,  state_d;
    owner_t              owner_q,  owner_d;
    logic [2:0]          size_q,   size_d;
    logic [1:0]          off_q,    off_d;
    logic                we_q,     we_d;
    logic                err_q,    err_d;
    logic [LAT_W-1:0]    lat_q,    lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic        rsp_cycle;
    logic        arb_en;
    logic        fetch_wins;
    logic        if_gnt;
    logic        lsu_gnt;
    logic        lsu_mem;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_wdata_lane;
    logic        lsu_misaligned;
    logic [31:0] lsu_rdata_ext;

    lsu_data_align u_align (
        .req_size_i   (lsu_size_i),
        .req_off_i    (lsu_addr_i[1:0]),
        .req_wdata_i  (lsu_wdata_i),
        .be_o         (lsu_be),
        .wdata_o      (lsu_wdata_lane),
        .misaligned_o (lsu_misaligned),
        .rsp_size_i   (size_q),
        .rsp_off_i    (off_q),
        .rsp_rdata_i  (mem_rdata_i),
        .rdata_o      (lsu_rdata_ext)
    );

    // Arbitration happens in IDLE or in the response cycle. Gating with rst_ni keeps
    // the combinational grants low while reset is held.
    assign rsp_cycle  = (state_q == ST_WAIT) && (lat_q == '0);
    assign arb_en     = rst_ni && ((state_q == ST_IDLE) || rsp_cycle);
    assign fetch_wins = if_req_i && (!lsu_req_i || (starve_q == STARVE_MAX));
    assign if_gnt     = arb_en && fetch_wins;
    assign lsu_gnt    = arb_en && lsu_req_i && !fetch_wins;
    // A misaligned or illegal LSU access is granted but never reaches memory.
    assign lsu_mem    = lsu_gnt && !lsu_misaligned;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        size_d   = size_q;
        off_d    = off_q;
        we_d     = we_q;
        err_d    = err_q;
        lat_d    = lat_q;
        starve_d = starve_q;

        if (state_q == ST_WAIT) begin
            if (lat_q != '0) lat_d   = lat_q - LAT_W'(1);
            else             state_d = ST_IDLE;
        end

        if (if_gnt) begin
            state_d = ST_WAIT;
            owner_d = OWN_IF;
            size_d  = LDST_W;
            off_d   = 2'b00;
            we_d    = 1'b0;
            err_d   = 1'b0;
            lat_d   = LAT_INIT;
        end else if (lsu_gnt) begin
            state_d = ST_WAIT;
            owner_d = OWN_LSU;
            size_d  = lsu_size_i;
            off_d   = lsu_addr_i[1:0];
            we_d    = lsu_we_i;
            err_d   = lsu_misaligned;
            // Error responses come back on the very next cycle regardless of MEM_LAT.
            lat_d   = lsu_misaligned ? '0 : LAT_INIT;
        end

        // An error grant leaves the starvation count untouched.
        if (if_gnt)
            starve_d = '0;
        else if (arb_en && if_req_i && !(lsu_gnt && lsu_misaligned) &&
                 (starve_q != STARVE_MAX))
            starve_d = starve_q + STARVE_W'(1);
    end

    // NOTE: the latched transaction fields are reset along with the state, so no
    // stale owner, size or error flag can shape an output after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            size_q   <= LDST_B;
            off_q    <= 2'b00;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            lat_q    <= '0;
            starve_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            owner_q  <= owner_d;
            size_q   <= size_d;
            off_q    <= off_d;
            we_q     <= we_d;
            err_q    <= err_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end

    assign if_gnt_o     = if_gnt;
    assign lsu_gnt_o    = lsu_gnt;
    assign if_rvalid_o  = rsp_cycle && (owner_q == OWN_IF);
    assign lsu_rvalid_o = rsp_cycle && (owner_q == OWN_LSU);
    assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : 32'h0;
    assign lsu_err_o    = lsu_rvalid_o && err_q;
    assign lsu_rdata_o  = (lsu_rvalid_o && !we_q && !err_q) ? lsu_rdata_ext : 32'h0;

    assign mem_req_o   = if_gnt || lsu_mem;
    assign mem_we_o    = lsu_mem && lsu_we_i;
    assign mem_be_o    = if_gnt ? 4'b1111 : (lsu_mem ? lsu_be : 4'b0000);
    assign mem_addr_o  = if_gnt  ? (if_addr_i  & 32'hFFFF_FFFC) :
                         lsu_mem ? (lsu_addr_i & 32'hFFFF_FFFC) : 32'h0;
    assign mem_wdata_o = (lsu_mem && lsu_we_i) ? lsu_wdata_lane : 32'h0;

    assign busy_o = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, mem_rdata_i;

    // MEM_LAT=1 instance
    logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, lsu_err, mem_req, mem_we, busy;
    logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    // MEM_LAT=3 instance
    logic        if_gnt3, if_rvalid3, lsu_gnt3, lsu_rvalid3, lsu_err3, mem_req3, mem_we3, busy3;
    logic [31:0] if_rdata3, lsu_rdata3, mem_addr3, mem_wdata3;
    logic [3:0]  mem_be3;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.MEM_LAT(1), .STARVE_LIM(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_err_o(lsu_err), .lsu_rdata_o(lsu_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy)
    );

    mem_arbiter #(.MEM_LAT(3), .STARVE_LIM(3)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt3),
        .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt3),
        .lsu_rvalid_o(lsu_rvalid3), .lsu_err_o(lsu_err3), .lsu_rdata_o(lsu_rdata3),
        .mem_req_o(mem_req3), .mem_we_o(mem_we3), .mem_be_o(mem_be3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [2:0]  size;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // size, we, addr, wdata, rdata | req, we, be, maddr, mwdata, rdata, err
        vecs[0]  = '{LDST_B,  1'b0, 32'h103, 32'h0,        32'h80FF_1234, 1'b1, 1'b0, 4'b1000, 32'h100, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{LDST_BU, 1'b0, 32'h103, 32'h0,        32'h80FF_1234, 1'b1, 1'b0, 4'b1000, 32'h100, 32'h0,         32'h0000_0080, 1'b0};
        vecs[2]  = '{LDST_H,  1'b1, 32'h202, 32'h0000_ABCD, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCD_ABCD, 32'h0,         1'b0};
        vecs[3]  = '{LDST_W,  1'b0, 32'h101, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1};
        vecs[4]  = '{LDST_H,  1'b0, 32'h102, 32'h0,        32'h8001_0000, 1'b1, 1'b0, 4'b1100, 32'h100, 32'h0,         32'hFFFF_8001, 1'b0};
        vecs[5]  = '{LDST_HU, 1'b0, 32'h100, 32'h0,        32'h1234_F00D, 1'b1, 1'b0, 4'b0011, 32'h100, 32'h0,         32'h0000_F00D, 1'b0};
        vecs[6]  = '{LDST_W,  1'b0, 32'h104, 32'h0,        32'hCAFE_BABE, 1'b1, 1'b0, 4'b1111, 32'h104, 32'h0,         32'hCAFE_BABE, 1'b0};
        vecs[7]  = '{LDST_B,  1'b1, 32'h001, 32'h0000_005A, 32'h0,        1'b1, 1'b1, 4'b0010, 32'h0,   32'h5A5A_5A5A, 32'h0,         1'b0};
        vecs[8]  = '{3'd3,    1'b0, 32'h000, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1};
        vecs[9]  = '{LDST_H,  1'b0, 32'h103, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1};
        vecs[10] = '{LDST_B,  1'b0, 32'h101, 32'h0,        32'h0000_7F00, 1'b1, 1'b0, 4'b0010, 32'h100, 32'h0,         32'h0000_007F, 1'b0};
        vecs[11] = '{LDST_W,  1'b1, 32'h3FC, 32'h1122_3344, 32'h0000_FFFF, 1'b1, 1'b1, 4'b1111, 32'h3FC, 32'h1122_3344, 32'h0,         1'b0};

        // Reset with both requests asserted: every output must stay low.
        rst_ni = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h40;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        check("rst_gnts",   {30'h0, if_gnt, lsu_gnt}, 32'h0);
        check("rst_mem",    {27'h0, mem_req, mem_be}, 32'h0);
        check("rst_rvalid", {29'h0, if_rvalid, lsu_rvalid, busy}, 32'h0);
        check("rst_rdata",  if_rdata | lsu_rdata | mem_addr, 32'h0);
        if_req_i = 1'b0; lsu_req_i = 1'b0; mem_rdata_i = 32'h0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // Single LSU transactions, MEM_LAT=1.
        for (int i = 0; i < NV; i++) begin
            lsu_req_i = 1'b1; lsu_we_i = vecs[i].we; lsu_size_i = vecs[i].size;
            lsu_addr_i = vecs[i].addr; lsu_wdata_i = vecs[i].wdata; mem_rdata_i = 32'h0;
            @(negedge clk_i);
            check($sformatf("v%0d_gnt", i),    {31'h0, lsu_gnt},  32'h1);
            check($sformatf("v%0d_memreq", i), {31'h0, mem_req},  {31'h0, vecs[i].exp_req});
            check($sformatf("v%0d_memwe", i),  {31'h0, mem_we},   {31'h0, vecs[i].exp_we});
            check($sformatf("v%0d_be", i),     {28'h0, mem_be},   {28'h0, vecs[i].exp_be});
            check($sformatf("v%0d_addr", i),   mem_addr,          vecs[i].exp_maddr);
            check($sformatf("v%0d_wdata", i),  mem_wdata,         vecs[i].exp_mwdata);
            next_cycle();
            lsu_req_i = 1'b0; mem_rdata_i = vecs[i].rdata;
            @(negedge clk_i);
            check($sformatf("v%0d_rvalid", i), {31'h0, lsu_rvalid}, 32'h1);
            check($sformatf("v%0d_rdata", i),  lsu_rdata,           vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i),    {31'h0, lsu_err},    {31'h0, vecs[i].exp_err});
            next_cycle();
        end

        // Both request at once: LSU first, fetch granted in the LSU response cycle.
        if_req_i = 1'b1; if_addr_i = 32'h40;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h8;
        mem_rdata_i = 32'h0;
        @(negedge clk_i);
        check("both_c0_lsu_gnt", {31'h0, lsu_gnt}, 32'h1);
        check("both_c0_if_gnt",  {31'h0, if_gnt},  32'h0);
        next_cycle();
        lsu_req_i = 1'b0; mem_rdata_i = 32'h1111_2222;
        @(negedge clk_i);
        check("both_c1_lsu_rvalid", {31'h0, lsu_rvalid}, 32'h1);
        check("both_c1_lsu_rdata",  lsu_rdata,           32'h1111_2222);
        check("both_c1_if_gnt",     {31'h0, if_gnt},     32'h1);
        check("both_c1_if_addr",    mem_addr,            32'h40);
        check("both_c1_if_be",      {28'h0, mem_be},     32'hF);
        next_cycle();
        if_req_i = 1'b0; mem_rdata_i = 32'h3333_4444;
        @(negedge clk_i);
        check("both_c2_if_rvalid",  {31'h0, if_rvalid},  32'h1);
        check("both_c2_if_rdata",   if_rdata,            32'h3333_4444);
        check("both_c2_lsu_rvalid", {31'h0, lsu_rvalid}, 32'h0);
        next_cycle();

        // Continuous contention: fetch wins the 4th arbitration, then LSU again.
        if_req_i = 1'b1; lsu_req_i = 1'b1; lsu_size_i = LDST_W; lsu_addr_i = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("starve_c%0d_if_gnt", c),  {31'h0, if_gnt},  {31'h0, c == 3});
            check($sformatf("starve_c%0d_lsu_gnt", c), {31'h0, lsu_gnt}, {31'h0, c != 3});
            next_cycle();
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        next_cycle();
        next_cycle();

        // Error grants do not advance the starvation count: LSU keeps winning.
        if_req_i = 1'b1; lsu_req_i = 1'b1; lsu_size_i = LDST_W; lsu_addr_i = 32'h2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("errstarve_c%0d_gnts", c), {30'h0, if_gnt, lsu_gnt}, 32'h1);
            check($sformatf("errstarve_c%0d_memreq", c), {31'h0, mem_req}, 32'h0);
            next_cycle();
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        repeat (5) next_cycle();

        // MEM_LAT=3: response exactly three cycles after grant.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h10;
        mem_rdata_i = 32'hA5A5_0003;
        @(negedge clk_i);
        check("lat3_gnt", {31'h0, lsu_gnt3}, 32'h1);
        next_cycle();
        lsu_req_i = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk_i);
            check($sformatf("lat3_c%0d_wait", c), {30'h0, lsu_rvalid3, busy3}, 32'h1);
            next_cycle();
        end
        @(negedge clk_i);
        check("lat3_c3_rvalid", {31'h0, lsu_rvalid3}, 32'h1);
        check("lat3_c3_rdata",  lsu_rdata3,           32'hA5A5_0003);
        next_cycle();
        repeat (3) next_cycle();

        // MEM_LAT=3: reset one cycle after grant discards the transaction.
        lsu_req_i = 1'b1; lsu_addr_i = 32'h20;
        @(negedge clk_i);
        check("rstw_gnt", {31'h0, lsu_gnt3}, 32'h1);
        next_cycle();
        lsu_req_i = 1'b0; rst_ni = 1'b0;
        @(negedge clk_i);
        check("rstw_in_reset", {30'h0, lsu_rvalid3, busy3}, 32'h0);
        next_cycle();
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("rstw_after_c%0d", c), {30'h0, lsu_rvalid3, busy3}, 32'h0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning cycles from grant to read data (legal 1..4).
REQ-002 Parameter STARVE_LIM, default 3, meaning consecutive fetch denials before fetch gets priority (legal 1..7).
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 if_req_i  in  1  fetch request, held until if_gnt_o.
REQ-006 if_addr_i  in  32  fetch byte address, word-aligned.
REQ-007 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid.
REQ-009 if_rdata_o  out  32  fetched instruction word.
REQ-010 lsu_req_i / lsu_we_i  in  1/1  data request / write.
REQ-011 lsu_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
REQ-012 lsu_addr_i / lsu_wdata_i  in  32/32  byte address / store data (LSB-aligned).
REQ-013 lsu_gnt_o / lsu_rvalid_o / lsu_err_o  out  1/1/1  accepted / response pulse / misaligned flag (valid with rvalid).
REQ-014 lsu_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-015 mem_req_o / mem_we_o  out  1/1  memory access strobe / write.
REQ-016 mem_be_o  out  4  byte enables.
REQ-017 mem_addr_o / mem_wdata_o  out  32/32  word address (addr[1:0] forced 0) / lane-shifted store data.
REQ-018 mem_rdata_i  in  32  memory word, valid MEM_LAT cycles after mem_req_o.
REQ-019 busy_o  out  1  high while a transaction is outstanding (core stall source).

Function
REQ-020 FSM states IDLE and WAIT; one outstanding transaction maximum.
REQ-021 Arbitration occurs only in IDLE, or in the WAIT cycle that produces rvalid; gnt is combinational in that cycle, and mem_req_o is asserted in the same cycle for exactly one cycle.
REQ-022 LSU has priority over fetch unless the starvation counter equals STARVE_LIM; then fetch wins.
REQ-023 The starvation counter increments on each arbitration cycle where if_req_i=1 and fetch is not granted, clears on fetch grant, and saturates at STARVE_LIM.
REQ-024 On grant: latch owner, size and addr[1:0], load a latency counter with MEM_LAT-1, and enter WAIT.
REQ-025 In WAIT, decrement the counter; when it is 0, capture mem_rdata_i and pulse the owner's rvalid exactly MEM_LAT cycles after the grant cycle.
REQ-026 Back-to-back transactions: a new grant is allowed in the rvalid cycle, giving one transaction per MEM_LAT cycles.
REQ-027 Stores also produce rvalid (write acknowledge) with lsu_rdata_o=0.
REQ-028 Byte enables: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111. Store data is replicated or shifted into those lanes.
REQ-029 Load extraction: select the lane by the latched offset. B/H sign-extend; BU/HU zero-extend; W is passed through.
REQ-030 Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) or an illegal size code: grant, no mem_req_o, rvalid next cycle with lsu_err_o=1 and no starvation update.
REQ-031 A request dropped before grant has no effect; after grant, request inputs are ignored until rvalid.
REQ-032 The other requester's gnt stays 0 while busy; if_gnt_o and lsu_gnt_o are never high together.

Reset
REQ-033 While rst_ni=0: state IDLE, counters 0; all outputs 0.
REQ-034 Reset mid-WAIT discards the transaction; no rvalid is ever issued for it.

Structure
REQ-035 Package mem_arb_pkg holds the state enum, owner enum (OWN_IF, OWN_LSU) and LDST size constants.
REQ-036 Byte-enable, store-lane and load-extension logic reside in sub-module lsu_data_align (purely combinational).

Verification
REQ-037 MEM_LAT=1, both requesters request at cycle 0 -> lsu_gnt_o at 0, lsu_rvalid_o at 1, if_gnt_o at 1, if_rvalid_o at 2.
REQ-038 Continuous lsu_req_i and if_req_i with STARVE_LIM=3 -> fetch granted on the 4th arbitration cycle, then the counter returns to 0.
REQ-039 Load LDST_B at addr 0x103 with mem_rdata_i=0x80FF_1234 -> mem_be_o=1000, lsu_rdata_o=0xFFFF_FF80. With LDST_BU -> 0x0000_0080.
REQ-040 Store LDST_H at 0x202 with wdata 0x0000_ABCD -> mem_be_o=1100, mem_wdata_o[31:16]=0xABCD, mem_addr_o=0x200, lsu_rdata_o=0.
REQ-041 Load LDST_W at 0x101 -> no mem_req_o; lsu_rvalid_o and lsu_err_o high one cycle after grant.
REQ-042 MEM_LAT=3, rst_ni pulsed low one cycle after grant -> no rvalid appears, and busy_o=0 after reset.
